serial_demux_1_a_8: RTL
=======================

// Module: serial_demux_1_a_8
// PURPOSE
//  Receive end of the 8:1 bit-select path: rebuilds a WIDTH-bit word from a 1-bit stream, one bit per
//  accepted cycle. Auto mode: bit position comes from an internal index counter, and sel_out drives the
//  remote selector. Addressed mode: position comes from sel_in, in any order. Sits behind the tt_um top,
//  fed from ui_in/uio_in; the completed word goes to uo_out.
// PARAMETERS
//  WIDTH  8          word width; power of two, >=2
//  SEL_W  $clog2(WIDTH)  index width (3 at default)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  bit_in      in   1      serial data bit
//  bit_valid   in   1      bit_in (and sel_in) valid this cycle
//  sel_in      in   SEL_W  bit position; used in addressed mode only
//  mode        in   1      0=auto index, 1=addressed; latched on first bit of a frame
//  clear       in   1      synchronous frame abort
//  data_out    out  WIDTH  last completed word; held until next completion
//  data_valid  out  1      one-cycle pulse: data_out updated
//  sel_out     out  SEL_W  auto: next index to fill; addressed: count of distinct positions filled
//  busy        out  1      frame in progress (state COLLECT)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, accumulator=0, fill mask=0, index=0.
//   Outputs: data_out=0, data_valid=0, sel_out=0, busy=0.
//  FSM IDLE -> COLLECT on first accepted bit; mode latched at that edge.
//   COLLECT -> IDLE on completion or clear. No DONE state, no bubble.
//  Accept = bit_valid & ~clear. bit_valid=0 cycles: all state held, counter does not advance.
//  Auto mode:
//   - acc[index] <= bit_in; index increments mod WIDTH; bit 0 is first.
//   - Completion = accept with index==WIDTH-1.
//  Addressed mode:
//   - acc[sel_in] <= bit_in; mask[sel_in] <= 1.
//   - Rewriting a filled position overwrites the data; count is unchanged.
//   - Completion = accept making mask all-ones.
//  Completion edge:
//   - data_out <= acc with the final bit merged in; data_valid=1 for exactly the next cycle.
//   - acc, mask and index are zeroed at the same edge, so a bit on the very next cycle starts the new frame.
//   - Latency: final bit sampled at edge N -> data_out/data_valid visible after edge N.
//  clear:
//   - Returns to IDLE and zeroes acc, mask and index; data_out is retained; no data_valid.
//   - clear and bit_valid in the same cycle: clear wins, the bit is discarded.
//  mode changes while busy are ignored until the frame ends.
//  Reset mid-frame: partial frame lost; outputs drop to reset values immediately.
// STRUCTURE
//  Shared package (itesm_tiny_pkg): WIDTH default, SEL_W, FSM state encodings ST_IDLE/ST_COLLECT.
//  One sub-module: serial_demux_index_ctr (mod-WIDTH counter, en/clr, terminal-count flag).
//  Everything else is inline: accumulator, mask, FSM, output registers.
// TESTING
//  1 Auto, 8 consecutive bits 1,0,1,1,0,0,1,0 -> data_out=8'h4D, one data_valid pulse;
//    sel_out steps 0..7, then 0.
//  2 Addressed, sel 7,3,0,5,1,6,2,4 carrying bits of 8'hA5; extra sel=3 write mid-frame
//    -> data_out=8'hA5 only after the 8th distinct position; sel_out peaks at 7 before wrap.
//  3 Auto with bit_valid low 1-3 cycles between bits of 8'h96 -> index holds during gaps; data_out=8'h96.
//  4 Auto, 5 bits, then clear asserted together with bit_valid, then full frame 8'h3C
//    -> no pulse for the aborted frame; data_out=8'h3C.
//  5 rst_n low after 4 bits of a frame -> data_out=0, busy=0, sel_out=0 immediately; next frame decodes.
//  6 16 back-to-back bits: 8'hFF then 8'h00 -> two data_valid pulses exactly 8 cycles apart,
//    data_out FF then 00.

Source files
------------

// File: rtl/itesm_tiny_pkg.sv
// Shared constants for the tiny serial bit-select path: default word width,
// index width and FSM state encodings.
package itesm_tiny_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int SEL_W_DEF = $clog2(WIDTH_DEF);

   // One-bit state encoding kept as plain constants for older tooling.
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/serial_demux_index_ctr.sv
// Mod-WIDTH bit-position counter. Clear has priority over enable.
// tc flags that the current count is the last position of the word.
module serial_demux_index_ctr import itesm_tiny_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [SEL_W-1:0] cnt,
   output logic             tc
);

   assign tc = (cnt == SEL_W'(WIDTH - 1));

   // Count accepted bits; wraps naturally because WIDTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/serial_demux_1_a_8.sv
// Receive side of the 8:1 bit-select link: rebuilds a WIDTH-bit word from a
// serial stream, either in auto order (internal index) or addressed order
// (sel_in per bit, completion once every position has been written).
module serial_demux_1_a_8 import itesm_tiny_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic [SEL_W-1:0] sel_in,
   input  logic             mode,
   input  logic             clear,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic [SEL_W-1:0] sel_out,
   output logic             busy
);

   logic [0:0]       state;
   logic             mode_r;
   logic             eff_mode;
   logic             accept;
   logic             done;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] mask_nxt;
   logic [WIDTH-1:0] sel_hot;
   logic [SEL_W-1:0] idx;
   logic             idx_tc;
   logic [SEL_W-1:0] fill_cnt;

   // Mode is taken live on the first bit of a frame, then from the latch.
   assign eff_mode = (state == ST_COLLECT) ? mode_r : mode;
   assign accept   = bit_valid & ~clear;
   assign busy     = (state == ST_COLLECT);

   serial_demux_index_ctr #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept & ~eff_mode),
      .clr   (clear | done),
      .cnt   (idx),
      .tc    (idx_tc)
   );

   // Merge the incoming bit at its position and update the fill mask.
   always_comb begin
      sel_hot          = '0;
      sel_hot[sel_in]  = 1'b1;
      acc_nxt          = acc;
      if (eff_mode)
         acc_nxt[sel_in] = bit_in;
      else
         acc_nxt[idx]    = bit_in;
      mask_nxt = mask | sel_hot;
   end

   assign done = accept & (eff_mode ? (&mask_nxt) : idx_tc);

   // Number of distinct positions filled so far in addressed mode.
   always_comb begin
      fill_cnt = '0;
      for (int i = 0; i < WIDTH; i++)
         fill_cnt = fill_cnt + SEL_W'(mask[i]);
   end

   assign sel_out = eff_mode ? fill_cnt : idx;

   // Frame FSM with accumulator and mask; completion and clear both restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         mode_r <= 1'b0;
         acc    <= '0;
         mask   <= '0;
      end else if (clear || done) begin
         state  <= ST_IDLE;
         acc    <= '0;
         mask   <= '0;
      end else if (accept) begin
         state <= ST_COLLECT;
         acc   <= acc_nxt;
         if (eff_mode)
            mask <= mask_nxt;
         if (state == ST_IDLE)
            mode_r <= mode;
      end
   end

   // Output word register and its one-cycle update strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= done;
         if (done)
            data_out <= acc_nxt;
      end
   end

endmodule
